// File: rtl/gate_bank_reg.sv
// Registered, runtime-configurable bank of two-input gates (AND/OR/XOR/NAND per channel)
// with a valid/ready operand port and a 2-deep result buffer.
module gate_bank_reg #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 1,
    localparam int unsigned DW      = CHANNELS * WIDTH,
    localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_a,
    input  logic [DW-1:0]       in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_y,
    output logic [CHANNELS-1:0] out_zero,
    input  logic                cfg_we,
    input  logic [CW-1:0]       cfg_ch,
    input  logic [1:0]          cfg_op
);

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    logic [CHANNELS-1:0][1:0] cfg_q, cfg_d;
    logic [DW-1:0]            head_y_q, head_y_d, tail_y_q, tail_y_d;
    logic [CHANNELS-1:0]      head_z_q, head_z_d, tail_z_q, tail_z_d;
    logic [1:0]               count_q, count_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;

    logic [DW-1:0]            res_y_c;
    logic [CHANNELS-1:0]      res_z_c;
    logic                     accept_c, pop_c;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_y     = head_y_q;
    assign out_zero  = head_z_q;

    // Gate evaluation uses the config held before the edge
    always_comb begin
        res_y_c = '0;
        res_z_c = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            case (cfg_q[k])
                OP_AND:  res_y_c[k*WIDTH +: WIDTH] = in_a[k*WIDTH +: WIDTH] & in_b[k*WIDTH +: WIDTH];
                OP_OR:   res_y_c[k*WIDTH +: WIDTH] = in_a[k*WIDTH +: WIDTH] | in_b[k*WIDTH +: WIDTH];
                OP_XOR:  res_y_c[k*WIDTH +: WIDTH] = in_a[k*WIDTH +: WIDTH] ^ in_b[k*WIDTH +: WIDTH];
                OP_NAND: res_y_c[k*WIDTH +: WIDTH] = ~(in_a[k*WIDTH +: WIDTH] & in_b[k*WIDTH +: WIDTH]);
                default: res_y_c[k*WIDTH +: WIDTH] = '0;
            endcase
            res_z_c[k] = (res_y_c[k*WIDTH +: WIDTH] == '0);
        end
    end

    // Config writes; out-of-range indices match no entry and are dropped
    always_comb begin
        cfg_d = cfg_q;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (cfg_we && (cfg_ch == CW'(k))) begin
                cfg_d[k] = cfg_op;
            end
        end
    end

    // Two-slot shift buffer: head always drives the outputs directly
    always_comb begin
        accept_c = in_valid && in_ready_q;
        pop_c    = out_valid_q && out_ready;
        head_y_d = head_y_q;
        head_z_d = head_z_q;
        tail_y_d = tail_y_q;
        tail_z_d = tail_z_q;
        count_d  = count_q;

        if (accept_c && pop_c) begin
            head_y_d = res_y_c;
            head_z_d = res_z_c;
        end else if (accept_c) begin
            if (count_q == 2'd0) begin
                head_y_d = res_y_c;
                head_z_d = res_z_c;
            end else begin
                tail_y_d = res_y_c;
                tail_z_d = res_z_c;
            end
            count_d = count_q + 2'd1;
        end else if (pop_c) begin
            head_y_d = tail_y_q;
            head_z_d = tail_z_q;
            count_d  = count_q - 2'd1;
        end

        in_ready_d  = (count_d < 2'd2);
        out_valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q       <= '0;
            head_y_q    <= '0;
            head_z_q    <= '1;
            tail_y_q    <= '0;
            tail_z_q    <= '1;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            head_y_q    <= head_y_d;
            head_z_q    <= head_z_d;
            tail_y_q    <= tail_y_d;
            tail_z_q    <= tail_z_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: doc/gate_bank_reg.md
# gate_bank_reg

Parametrised, registered successor to the struct74 quad two-input gate parts: CHANNELS independent two-input gates, each WIDTH bits wide, with a per-channel runtime-selectable function (AND/OR/XOR/NAND). Operands enter through a valid/ready handshake. Results are held in a 2-entry output buffer, so back-pressure never drops data. The block sits in the struct74 library wherever a datapath needs a clocked, reconfigurable bank of gates rather than fixed 74-series glue.

## Interface
- CHANNELS, default 4: number of gate channels (1..16).
- WIDTH, default 1: bits per channel operand (1..32).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set on in_a/in_b is valid.
- in_ready  output  1  block can accept an operand set this cycle.
- in_a  input  CHANNELS*WIDTH  operand A; channel k at bits [k*WIDTH +: WIDTH].
- in_b  input  CHANNELS*WIDTH  operand B; same packing.
- out_valid  output  1  out_y/out_zero hold a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- out_y  output  CHANNELS*WIDTH  result; same packing.
- out_zero  output  CHANNELS  bit k is high when channel k of out_y is all zeros.
- cfg_we  input  1  write the function of one channel.
- cfg_ch  input  $clog2(CHANNELS) (minimum 1)  channel index to write.
- cfg_op  input  2  function code: 00 AND, 01 OR, 10 XOR, 11 NAND.

## Operation
- Config register: CHANNELS entries of 2 bits each. Reset value is 00 (AND) for every entry, so the post-reset bank behaves as CHANNELS AND gates.
- Config write: on a clk edge with cfg_we=1, entry cfg_ch takes cfg_op. When cfg_ch >= CHANNELS, the write is ignored.
- Operand accept: an operand set is accepted on a clk edge when in_valid && in_ready. Each channel computes with the config value held before that edge.
  - A config write on the same edge as an accept affects only later accepts.
- Per-channel results, evaluated bitwise over WIDTH bits:
  - AND: a & b
  - OR: a | b
  - XOR: a ^ b
  - NAND: ~(a & b)
- out_zero[k] is computed at accept time from the channel k result. It is stored with the entry.
- Output buffer: 2-entry FIFO of {y, zero}. count is 0..2.
  - Push on accept; pop when out_valid && out_ready.
  - Simultaneous push and pop leaves count unchanged and keeps order intact.
- in_ready = (count < 2). This is a registered function of state, with no combinational path from out_ready.
  - With count == 2 and out_ready == 1, the slot does not free up until the next cycle. in_ready stays low that cycle.
- out_valid = (count > 0). out_y/out_zero always show the head entry.
- in_valid while in_ready == 0: no accept. The producer must hold its data.
- rst_n low at any time, including mid-transfer:
  - count goes to 0 immediately (asynchronous).
  - Buffered results are discarded.
  - Config returns to all-AND.
- Outputs while rst_n is low and on release:
  - in_ready = 1, out_valid = 0, out_y = 0, out_zero = all ones.
  - Buffer storage resets to y = 0, zero = 1.

## Timing
- Latency: accept at edge N gives out_valid high after edge N with the result visible. The consumer can take it at edge N+1.
- Throughput: one operand set per cycle while out_ready stays high.
- When stalled (out_ready = 0):
  - Two results are accepted.
  - in_ready drops after the second accept.
  - out_y holds the first result stable until popped.
- out_* stay stable while out_valid && !out_ready.
- All state elements reset asynchronously on rst_n falling. They leave reset on the first clk edge after rst_n rises.

## Test plan
- Reset defaults:
  - Stimulus: after reset, CHANNELS=4, WIDTH=1, push a=4'b1111, b=4'b1010.
  - Required: out_y=4'b1010 one cycle later; out_zero=4'b0101.
- Per-channel functions:
  - Stimulus: configure ch0..ch3 as AND/OR/XOR/NAND with WIDTH=8, then push a=0xF0 and b=0x3C in every channel.
  - Required: channel results 0x30, 0xFC, 0xCC, 0xCF; out_zero=0.
- Config/accept race:
  - Stimulus: cfg_we (ch0 to OR) on the same edge as accepting a=0x0F, b=0xF0.
  - Required: that result is 0x00 (AND) with out_zero[0]=1. The next push of the same operands gives 0xFF.
- Back-pressure:
  - Stimulus: out_ready=0, push results R1, R2, R3.
  - Required: R1 and R2 are accepted; in_ready is low after R2 and R3 is held; out_y=R1 stays stable. Raising out_ready then delivers R1, R2, R3 in order with no loss.
- Streaming:
  - Stimulus: out_ready=1, in_valid high for 10 cycles.
  - Required: 10 results on 10 consecutive cycles, one cycle after each accept.
  - Stimulus: the same with count=2, pop and push requested on the same edge.
  - Required: the pop succeeds and the push is refused that cycle.
- Mid-operation reset and config bounds:
  - Stimulus: with count=2, pulse rst_n low between clock edges.
  - Required: out_valid=0 and in_ready=1 immediately; config is back to AND.
  - Stimulus: a write with cfg_ch=CHANNELS (CHANNELS=5).
  - Required: no channel changes.
